// File: rtl/io_wr_latch_wdog.sv
// CPU write decoder: control latch, sound command latch with IRQ handshake, stretched coin pulses.
// Optional watchdog CPU reset generator is built only when WDOG_EN is defined.
module io_wr_latch_wdog #(
  parameter int COIN_STRETCH = 8,
  parameter int WDOG_LIMIT   = 4095,
  parameter int WDOG_HOLD    = 16
) (
  input  logic       clk,
  input  logic       Rn,
  input  logic       ce,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       snd_ack,
  output logic [7:0] ctrl_q,
  output logic [7:0] snd_latch,
  output logic       snd_irq,
  output logic       coin1_pulse,
  output logic       coin2_pulse,
  output logic       wdog_rst_n
);

  localparam logic [7:0] COIN_LOAD = 8'(COIN_STRETCH);

  logic       wr_now;
  logic       wr_pulse;
  logic       wr_prev_q;
  logic       wr_ctrl;
  logic       wr_snd;
  logic       wr_coin;
  logic [7:0] ctrl_lat_q;
  logic [7:0] snd_lat_q;
  logic       snd_irq_q;
  logic [7:0] coin1_cnt_q, coin1_cnt_d;
  logic [7:0] coin2_cnt_q, coin2_cnt_d;
  logic       coin1_q;
  logic       coin2_q;

  // A held strobe spanning several CPU ticks produces a single write.
  assign wr_now   = ~cs_n & ~wr_n;
  assign wr_pulse = ce & wr_now & ~wr_prev_q;
  assign wr_ctrl  = wr_pulse & (addr == 2'd0);
  assign wr_snd   = wr_pulse & (addr == 2'd1);
  assign wr_coin  = wr_pulse & (addr == 2'd2);

  always_comb begin
    coin1_cnt_d = coin1_cnt_q;
    coin2_cnt_d = coin2_cnt_q;
    if (ce && coin1_cnt_q != 8'd0) coin1_cnt_d = coin1_cnt_q - 8'd1;
    if (ce && coin2_cnt_q != 8'd0) coin2_cnt_d = coin2_cnt_q - 8'd1;
    if (wr_coin && din[0]) coin1_cnt_d = COIN_LOAD;
    if (wr_coin && din[1]) coin2_cnt_d = COIN_LOAD;
  end

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      wr_prev_q   <= 1'b0;
      ctrl_lat_q  <= 8'h00;
      snd_lat_q   <= 8'h00;
      snd_irq_q   <= 1'b0;
      coin1_cnt_q <= 8'd0;
      coin2_cnt_q <= 8'd0;
      coin1_q     <= 1'b0;
      coin2_q     <= 1'b0;
    end else begin
      if (ce) wr_prev_q <= wr_now;
      if (wr_ctrl) ctrl_lat_q <= din;
      if (wr_snd) snd_lat_q <= din;
      if (wr_snd) snd_irq_q <= 1'b1;
      else if (snd_ack) snd_irq_q <= 1'b0;
      coin1_cnt_q <= coin1_cnt_d;
      coin2_cnt_q <= coin2_cnt_d;
      coin1_q     <= (coin1_cnt_d != 8'd0);
      coin2_q     <= (coin2_cnt_d != 8'd0);
    end
  end

  assign ctrl_q      = ctrl_lat_q;
  assign snd_latch   = snd_lat_q;
  assign snd_irq     = snd_irq_q;
  assign coin1_pulse = coin1_q;
  assign coin2_pulse = coin2_q;

`ifdef WDOG_EN
  typedef enum logic {WD_RUN, WD_FIRE} wd_state_t;

  localparam logic [15:0] WD_LIMIT = 16'(WDOG_LIMIT);
  localparam logic [15:0] WD_LAST  = 16'(WDOG_HOLD - 1);

  wd_state_t   wd_state_q;
  logic [15:0] wd_cnt_q;
  logic        wd_rst_n_q;
  logic        wr_kick;

  assign wr_kick = wr_pulse & (addr == 2'd3);

  // A kick landing on the limit tick keeps the CPU running; kicks while firing are ignored.
  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      wd_state_q <= WD_RUN;
      wd_cnt_q   <= 16'd0;
      wd_rst_n_q <= 1'b1;
    end else if (ce) begin
      case (wd_state_q)
        WD_RUN: begin
          if (wr_kick) begin
            wd_cnt_q <= 16'd0;
          end else if (wd_cnt_q == WD_LIMIT) begin
            wd_state_q <= WD_FIRE;
            wd_rst_n_q <= 1'b0;
            wd_cnt_q   <= 16'd0;
          end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
          end
        end
        WD_FIRE: begin
          if (wd_cnt_q == WD_LAST) begin
            wd_state_q <= WD_RUN;
            wd_rst_n_q <= 1'b1;
            wd_cnt_q   <= 16'd0;
          end else begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
          end
        end
        default: wd_state_q <= WD_RUN;
      endcase
    end
  end

  assign wdog_rst_n = wd_rst_n_q;
`else
  // Watchdog timing parameters have no effect when the watchdog is not built.
  logic wd_params_unused;
  assign wd_params_unused = ^{16'(WDOG_LIMIT), 8'(WDOG_HOLD)};
  assign wdog_rst_n = 1'b1;
`endif

endmodule
